// File: rtl/bitriquat_arbiter.sv
// bitriquat_arbiter: round-robin sharing of one NCL binary+trinary->quaternary adder between two clocked requesters (optional macro: WATCHDOG_EN).
// Latency: req->ack is at least 2*SYNC_STAGES+3 cycles with a zero-delay adder; an illegal t=3 operand is acked one cycle after grant.
// Backpressure: requesters hold req until a one-cycle ack; adder waits are unbounded unless WATCHDOG_EN bounds them to TIMEOUT cycles.
module bitriquat_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req0,
    input  logic       b0,
    input  logic [1:0] t0,
    output logic       ack0,
    output logic [1:0] sum0,
    input  logic       req1,
    input  logic       b1,
    input  logic [1:0] t1,
    output logic       ack1,
    output logic [1:0] sum1,
    output logic [1:0] binary,
    output logic [2:0] trinary,
    input  logic [3:0] quatout,
    output logic       quatcomp,
    output logic       err
);

    typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_DATA, S_NULLW} state_t;

    logic [1:0] r_rst_pipe;
    logic       w_rst;
    logic [3:0] r_qsync [SYNC_STAGES];
    logic [3:0] w_qs;
    logic       w_qs_null, w_qs_onehot, w_qs_multi;
    logic [1:0] w_qs_idx;

    state_t     r_state, w_state_nxt;
    logic       r_gnt, w_gnt_nxt;
    logic       r_rr, w_rr_nxt;
    logic [1:0] r_res, w_res_nxt;
    logic [1:0] r_binary, w_binary_nxt;
    logic [2:0] r_trinary, w_trinary_nxt;
    logic       r_quatcomp, w_quatcomp_nxt;
    logic       r_ack0, r_ack1, w_ack0_nxt, w_ack1_nxt;
    logic [1:0] r_sum0, r_sum1, w_sum0_nxt, w_sum1_nxt;
    logic       r_err, w_err_nxt;

    logic       w_fin, w_fin_id;
    logic [1:0] w_fin_sum;
    logic       w_sel, w_sel_b;
    logic [1:0] w_sel_t;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or posedge init) begin
        if (init) r_rst_pipe <= 2'b11;
        else      r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
    assign w_rst = r_rst_pipe[1];

    // Bring the asynchronous adder rails into the clock domain; left unreset so it tracks the adder through init.
    always_ff @(posedge clk) begin
        r_qsync[0] <= quatout;
        for (int i = 1; i < SYNC_STAGES; i++) r_qsync[i] <= r_qsync[i-1];
    end
    assign w_qs      = r_qsync[SYNC_STAGES-1];
    assign w_qs_null = (w_qs == 4'b0000);

    // Classify the synchronised result as NULL, a valid one-hot value, or corrupted multi-hot.
    always_comb begin
        w_qs_onehot = 1'b1;
        w_qs_idx    = 2'd0;
        case (w_qs)
            4'b0001: w_qs_idx = 2'd0;
            4'b0010: w_qs_idx = 2'd1;
            4'b0100: w_qs_idx = 2'd2;
            4'b1000: w_qs_idx = 2'd3;
            default: w_qs_onehot = 1'b0;
        endcase
    end
    assign w_qs_multi = !w_qs_null && !w_qs_onehot;

    // Round-robin pick: on contention the requester not served last wins.
    assign w_sel   = (req0 && req1) ? r_rr : req1;
    assign w_sel_b = w_sel ? b1 : b0;
    assign w_sel_t = w_sel ? t1 : t0;

`ifdef WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_hit;

    // Count cycles spent waiting on the adder; restart on every state change and saturate at the limit.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst)                                          r_wd_cnt <= '0;
        else if (w_state_nxt != r_state)                    r_wd_cnt <= '0;
        else if (r_state != S_IDLE && r_wd_cnt != WD_LAST)  r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
    assign w_wd_hit = (r_wd_cnt == WD_LAST) && (r_state != S_IDLE);
`endif

    // Next-state and output decisions for the four-phase handshake around the adder.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_rr_nxt       = r_rr;
        w_res_nxt      = r_res;
        w_binary_nxt   = r_binary;
        w_trinary_nxt  = r_trinary;
        w_quatcomp_nxt = r_quatcomp;
        w_err_nxt      = r_err;
        w_ack0_nxt     = 1'b0;
        w_ack1_nxt     = 1'b0;
        w_sum0_nxt     = r_sum0;
        w_sum1_nxt     = r_sum1;
        w_fin          = 1'b0;
        w_fin_id       = r_gnt;
        w_fin_sum      = 2'b00;
        case (r_state)
            S_DRAIN: begin
                w_binary_nxt   = 2'b00;
                w_trinary_nxt  = 3'b000;
                w_quatcomp_nxt = 1'b1;
                if (w_qs_null) begin
                    w_quatcomp_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req0 || req1) begin
                    if (w_sel_t == 2'd3) begin
                        // Illegal trinary operand never reaches the adder.
                        w_err_nxt = 1'b1;
                        w_fin     = 1'b1;
                        w_fin_id  = w_sel;
                        w_rr_nxt  = ~w_sel;
                    end else begin
                        w_gnt_nxt      = w_sel;
                        w_binary_nxt   = w_sel_b ? 2'b10 : 2'b01;
                        w_trinary_nxt  = (w_sel_t == 2'd0) ? 3'b001 :
                                         (w_sel_t == 2'd1) ? 3'b010 : 3'b100;
                        w_quatcomp_nxt = 1'b0;
                        w_state_nxt    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!w_qs_null) begin
                    w_res_nxt      = w_qs_onehot ? w_qs_idx : 2'b00;
                    w_err_nxt      = r_err | w_qs_multi;
                    w_binary_nxt   = 2'b00;
                    w_trinary_nxt  = 3'b000;
                    w_quatcomp_nxt = 1'b1;
                    w_state_nxt    = S_NULLW;
                end
            end
            S_NULLW: begin
                if (w_qs_null) begin
                    w_quatcomp_nxt = 1'b0;
                    w_fin          = 1'b1;
                    w_fin_sum      = r_res;
                    w_rr_nxt       = ~r_gnt;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_DRAIN;
        endcase
`ifdef WATCHDOG_EN
        if (w_wd_hit && w_state_nxt == r_state) begin
            w_err_nxt = 1'b1;
            if (r_state == S_DATA || r_state == S_NULLW) begin
                w_fin          = 1'b1;
                w_fin_id       = r_gnt;
                w_fin_sum      = 2'b00;
                w_rr_nxt       = ~r_gnt;
                w_binary_nxt   = 2'b00;
                w_trinary_nxt  = 3'b000;
                w_quatcomp_nxt = 1'b1;
                w_state_nxt    = S_DRAIN;
            end
        end
`endif
        if (w_fin) begin
            if (w_fin_id) begin
                w_ack1_nxt = 1'b1;
                w_sum1_nxt = w_fin_sum;
            end else begin
                w_ack0_nxt = 1'b1;
                w_sum0_nxt = w_fin_sum;
            end
        end
    end

    // State and output registers; reset leaves the adder draining with NULL rails.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state    <= S_DRAIN;
            r_gnt      <= 1'b0;
            r_rr       <= 1'b0;
            r_res      <= 2'b00;
            r_binary   <= 2'b00;
            r_trinary  <= 3'b000;
            r_quatcomp <= 1'b1;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_sum0     <= 2'b00;
            r_sum1     <= 2'b00;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr       <= w_rr_nxt;
            r_res      <= w_res_nxt;
            r_binary   <= w_binary_nxt;
            r_trinary  <= w_trinary_nxt;
            r_quatcomp <= w_quatcomp_nxt;
            r_ack0     <= w_ack0_nxt;
            r_ack1     <= w_ack1_nxt;
            r_sum0     <= w_sum0_nxt;
            r_sum1     <= w_sum1_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign binary   = r_binary;
    assign trinary  = r_trinary;
    assign quatcomp = r_quatcomp;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign sum0     = r_sum0;
    assign sum1     = r_sum1;
    assign err      = r_err;

endmodule
